uart_rx_fifo_mon: RTL and testbench

Parametrised UART receive channel with a buffered output, for the SoC serial path and the bench-side console monitor.
- Runtime-programmable baud divisor, data length, parity and stop bits.
- Per-character error tagging (parity, framing) and a receive FIFO with valid/ready drain.
- Sticky overflow flag.
- Generalises the fixed 8N1 bus model: one instance per UART channel, synthesizable, same clock domain as the peripheral subsystem.

---
 rtl/uart_rx_fifo_mon.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_fifo_mon.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_mon.sv
// UART receive channel: synchroniser, runtime-configurable frame decoder
// (5..8 data bits, optional parity, 1 or 2 stop bits) and a receive FIFO
// with a registered head entry and a sticky overflow flag.
`timescale 1ns/1ps
module uart_rx_fifo_mon #(
   parameter int FIFO_DEPTH  = 16,
   parameter int DIV_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx_i,
   input  logic                          rx_en_i,
   input  logic [DIV_WIDTH-1:0]          div_i,
   input  logic [1:0]                    data_bits_i,
   input  logic                          parity_en_i,
   input  logic                          parity_odd_i,
   input  logic                          stop2_i,
   output logic [7:0]                    data_o,
   output logic                          perr_o,
   output logic                          ferr_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          overflow_o,
   input  logic                          clr_ovf_i,
   output logic                          busy_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic [DIV_WIDTH-1:0]   div_eff;
   logic [DIV_WIDTH-1:0]   div_q;
   logic [DIV_WIDTH-1:0]   cnt;
   logic [1:0]             bits_q;
   logic                   par_en_q;
   logic                   par_odd_q;
   logic                   stop2_q;
   logic [2:0]             bit_idx;
   logic [7:0]             shreg;
   logic                   perr_q;
   logic                   ferr_q;

   logic                   push;
   logic                   push_ferr;
   logic [9:0]             wdata;
   logic                   pop;
   logic                   full;
   logic                   do_push;
   logic [9:0]             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       rd_ptr_nxt;
   logic [CNT_W-1:0]       count;
   logic [9:0]             head_q;
   logic                   ovf_q;

   assign rxs     = sync_q[SYNC_STAGES-1];
   assign div_eff = (div_i < DIV_WIDTH'(8)) ? DIV_WIDTH'(8) : div_i;

   // Metastability synchroniser on the asynchronous serial line; idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
   end

   // Frame decoder: bit timing, data assembly and parity/framing checks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         div_q     <= '0;
         bits_q    <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         stop2_q   <= 1'b0;
         bit_idx   <= '0;
         shreg     <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else if (!rx_en_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (!rxs) begin
               state     <= START;
               cnt       <= (div_eff >> 1) - 1'b1;
               div_q     <= div_eff;
               bits_q    <= data_bits_i;
               par_en_q  <= parity_en_i;
               par_odd_q <= parity_odd_i;
               stop2_q   <= stop2_i;
               bit_idx   <= '0;
               shreg     <= '0;
               perr_q    <= 1'b0;
               ferr_q    <= 1'b0;
            end
            START: if (cnt != '0) cnt <= cnt - 1'b1;
               else if (rxs) state <= IDLE;
               else begin
                  state <= DATA;
                  cnt   <= div_q - 1'b1;
               end
            DATA: if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  shreg[bit_idx] <= rxs;
                  cnt            <= div_q - 1'b1;
                  if (bit_idx == 3'(bits_q) + 3'd4) state <= par_en_q ? PARITY : STOP1;
                  else bit_idx <= bit_idx + 1'b1;
               end
            PARITY: if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  perr_q <= rxs != (^shreg ^ par_odd_q);
                  cnt    <= div_q - 1'b1;
                  state  <= STOP1;
               end
            STOP1: if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  ferr_q <= !rxs;
                  if (stop2_q) begin
                     state <= STOP2;
                     cnt   <= div_q - 1'b1;
                  end else state <= rxs ? IDLE : BREAK;
               end
            STOP2: if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  ferr_q <= ferr_q | !rxs;
                  state  <= (ferr_q | !rxs) ? BREAK : IDLE;
               end
            BREAK: if (rxs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The character is pushed in the cycle that samples its final stop bit.
   assign push      = rx_en_i && (cnt == '0) &&
                      ((state == STOP1 && !stop2_q) || state == STOP2);
   assign push_ferr = !rxs | ((state == STOP2) & ferr_q);
   assign wdata     = {perr_q, push_ferr, shreg};

   // Drain handshake: valid_o means the head entry is meaningful; an entry is
   // consumed on every clock edge where valid_o and ready_i are both high.
   assign pop        = valid_o & ready_i;
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign do_push    = push & (!full | pop);
   assign rd_ptr_nxt = rd_ptr + 1'b1;

   // FIFO storage; no reset needed because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // FIFO pointers, occupancy, registered head entry and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr_nxt;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) begin
            if (count > CNT_W'(1)) head_q <= mem[rd_ptr_nxt];
            else if (do_push)      head_q <= wdata;
         end else if (do_push && count == '0) begin
            head_q <= wdata;
         end
         if (push && full && !pop) ovf_q <= 1'b1;
         else if (clr_ovf_i)       ovf_q <= 1'b0;
      end
   end

   assign data_o     = head_q[7:0];
   assign ferr_o     = head_q[8];
   assign perr_o     = head_q[9];
   assign valid_o    = (count != '0);
   assign count_o    = count;
   assign overflow_o = ovf_q;
   assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_mon.sv
// Directed bench for uart_rx_fifo_mon: frame timing, parity/framing errors,
// BREAK handling, glitch rejection, overflow, full push+pop, reset and
// disable mid-frame.
`timescale 1ns/1ps
module tb_uart_rx_fifo_mon;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_i = 1'b1;
   logic        rx_en_i = 1'b1;
   logic [15:0] div_i = 16'd32;
   logic [1:0]  data_bits_i = 2'b11;
   logic        parity_en_i = 1'b0;
   logic        parity_odd_i = 1'b0;
   logic        stop2_i = 1'b0;
   logic [7:0]  data_o;
   logic        perr_o;
   logic        ferr_o;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [4:0]  count_o;
   logic        overflow_o;
   logic        clr_ovf_i = 1'b0;
   logic        busy_o;

   int n_cmp = 0;
   int n_bad = 0;

   uart_rx_fifo_mon #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_en_i(rx_en_i), .div_i(div_i),
      .data_bits_i(data_bits_i), .parity_en_i(parity_en_i),
      .parity_odd_i(parity_odd_i), .stop2_i(stop2_i), .data_o(data_o),
      .perr_o(perr_o), .ferr_o(ferr_o), .valid_o(valid_o), .ready_i(ready_i),
      .count_o(count_o), .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i),
      .busy_o(busy_o)
   );

   // Clock
   always #5 clk = ~clk;

   // Time limit
   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges; returns 1 time unit after the last edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic v, input int d);
      rx_i = v;
      tick(d);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input int div,
                             input bit par_en, input bit par_val, input bit s1,
                             input bit two_stop, input bit s2);
      drive_bit(1'b0, div);
      for (int i = 0; i < nbits; i++) drive_bit(d[i], div);
      if (par_en) drive_bit(par_val, div);
      drive_bit(s1, div);
      if (two_stop) drive_bit(s2, div);
   endtask

   task automatic send8(input logic [7:0] d, input int div);
      send_frame(d, 8, div, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 4);
   endtask

   task automatic pop_one();
      ready_i = 1'b1;
      tick(1);
      ready_i = 1'b0;
   endtask

   initial begin
      logic [7:0] v;

      // Reset
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check("rst_data", 32'(data_o), 32'h0);
      check("rst_perr", 32'(perr_o), 32'h0);
      check("rst_ferr", 32'(ferr_o), 32'h0);
      check("rst_valid", 32'(valid_o), 32'h0);
      check("rst_count", 32'(count_o), 32'h0);
      check("rst_ovf", 32'(overflow_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);

      // 8N1 div=32, 0x65: stop sampled 307 edges after the start edge
      v = 8'h65;
      drive_bit(1'b0, 32);
      for (int i = 0; i < 8; i++) drive_bit(v[i], 32);
      rx_i = 1'b1;
      tick(18);
      check("t1_valid_early", 32'(valid_o), 32'h0);
      tick(1);
      check("t1_valid", 32'(valid_o), 32'h1);
      check("t1_data", 32'(data_o), 32'h65);
      check("t1_perr", 32'(perr_o), 32'h0);
      check("t1_ferr", 32'(ferr_o), 32'h0);
      check("t1_count", 32'(count_o), 32'h1);
      tick(17);
      pop_one();
      check("t1_count_pop", 32'(count_o), 32'h0);
      check("t1_valid_pop", 32'(valid_o), 32'h0);
      check("t1_data_hold", 32'(data_o), 32'h65);

      // 7E2 div=16: bad parity, then framing error into BREAK
      div_i = 16'd16; data_bits_i = 2'b10; parity_en_i = 1'b1;
      parity_odd_i = 1'b0; stop2_i = 1'b1;
      send_frame(8'h41, 7, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      drive_bit(1'b1, 8);
      check("t2_data", 32'(data_o), 32'h41);
      check("t2_perr", 32'(perr_o), 32'h1);
      check("t2_ferr", 32'(ferr_o), 32'h0);
      check("t2_count", 32'(count_o), 32'h1);
      pop_one();
      send_frame(8'h41, 7, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(40);
      check("t2_break_busy", 32'(busy_o), 32'h1);
      check("t2_break_count", 32'(count_o), 32'h1);
      check("t2_f_data", 32'(data_o), 32'h41);
      check("t2_f_perr", 32'(perr_o), 32'h0);
      check("t2_f_ferr", 32'(ferr_o), 32'h1);
      drive_bit(1'b1, 4);
      check("t2_release_busy", 32'(busy_o), 32'h0);
      check("t2_release_count", 32'(count_o), 32'h1);
      pop_one();

      // Glitch: 5 low cycles at div=32
      div_i = 16'd32; data_bits_i = 2'b11; parity_en_i = 1'b0; stop2_i = 1'b0;
      drive_bit(1'b0, 5);
      check("t3_busy_start", 32'(busy_o), 32'h1);
      drive_bit(1'b1, 20);
      check("t3_busy_idle", 32'(busy_o), 32'h0);
      check("t3_count", 32'(count_o), 32'h0);

      // Overflow: 17 characters into a 16-entry FIFO
      div_i = 16'd16;
      for (int i = 0; i <= 16; i++) send8(8'(i), 16);
      check("t4_count", 32'(count_o), 32'd16);
      check("t4_ovf", 32'(overflow_o), 32'h1);
      for (int i = 0; i < 16; i++) begin
         check("t4_drain", 32'(data_o), 32'(i));
         pop_one();
      end
      check("t4_empty", 32'(count_o), 32'h0);
      check("t4_ovf_sticky", 32'(overflow_o), 32'h1);
      clr_ovf_i = 1'b1;
      tick(1);
      clr_ovf_i = 1'b0;
      check("t4_ovf_clr", 32'(overflow_o), 32'h0);

      // Full FIFO: push and pop on the same edge (stop sample at edge 155)
      for (int i = 0; i < 16; i++) send8(8'h20 + 8'(i), 16);
      check("t5_full", 32'(count_o), 32'd16);
      v = 8'h30;
      drive_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) drive_bit(v[i], 16);
      rx_i = 1'b1;
      tick(10);
      ready_i = 1'b1;
      tick(1);
      ready_i = 1'b0;
      check("t5_count", 32'(count_o), 32'd16);
      check("t5_ovf", 32'(overflow_o), 32'h0);
      check("t5_head", 32'(data_o), 32'h21);
      drive_bit(1'b1, 9);
      for (int i = 0; i < 16; i++) begin
         check("t5_drain", 32'(data_o), 32'h21 + 32'(i));
         pop_one();
      end
      check("t5_empty", 32'(count_o), 32'h0);

      // Async reset during the data bits of 0xA5
      send8(8'h11, 16);
      check("t6_pre_count", 32'(count_o), 32'h1);
      v = 8'hA5;
      drive_bit(1'b0, 16);
      for (int i = 0; i < 3; i++) drive_bit(v[i], 16);
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", 32'(busy_o), 32'h0);
      check("t6_rst_count", 32'(count_o), 32'h0);
      check("t6_rst_valid", 32'(valid_o), 32'h0);
      check("t6_rst_data", 32'(data_o), 32'h0);
      rx_i = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      send8(8'h3C, 16);
      check("t6_count", 32'(count_o), 32'h1);
      check("t6_data", 32'(data_o), 32'h3C);
      check("t6_err", 32'({perr_o, ferr_o}), 32'h0);
      pop_one();

      // rx_en_i dropped during the data bits of 0xA5
      send8(8'h12, 16);
      drive_bit(1'b0, 16);
      for (int i = 0; i < 3; i++) drive_bit(v[i], 16);
      rx_en_i = 1'b0;
      tick(2);
      check("t7_dis_busy", 32'(busy_o), 32'h0);
      check("t7_dis_count", 32'(count_o), 32'h1);
      check("t7_dis_data", 32'(data_o), 32'h12);
      for (int i = 3; i < 8; i++) drive_bit(v[i], 16);
      drive_bit(1'b1, 20);
      check("t7_after_count", 32'(count_o), 32'h1);
      rx_en_i = 1'b1;
      tick(2);
      send8(8'h3C, 16);
      check("t7_count", 32'(count_o), 32'h2);
      check("t7_head", 32'(data_o), 32'h12);
      pop_one();
      check("t7_second", 32'(data_o), 32'h3C);
      check("t7_count1", 32'(count_o), 32'h1);
      pop_one();
      check("t7_empty", 32'(count_o), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
